// File: rtl/t_stream_feeder_if.sv
// -----------------------------------------------------------------------------
// t_stream_feeder_if
// Upstream stream bundle feeding the Smith-Waterman PE[0] feeder.
//   t_char / t_valid / t_ready        : target symbol stream (2-bit symbols)
//   bnd_v / bnd_f / bnd_valid / bnd_ready : boundary column replayed from the
//                                        last-PE column store
// Modports:
//   master : upstream producer (drives data/valid, sees ready)
//   slave  : the feeder (sees data/valid, drives ready)
// Data width defaults to `V_E_F_Bit (falls back to 16 when param.v is absent).
// -----------------------------------------------------------------------------
`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif

interface t_stream_feeder_if #(
  parameter int W = `V_E_F_Bit
);
  logic [1:0]   t_char;
  logic         t_valid;
  logic         t_ready;
  logic [W-1:0] bnd_v;
  logic [W-1:0] bnd_f;
  logic         bnd_valid;
  logic         bnd_ready;

  modport master (
    output t_char, t_valid, bnd_v, bnd_f, bnd_valid,
    input  t_ready, bnd_ready
  );

  modport slave (
    input  t_char, t_valid, bnd_v, bnd_f, bnd_valid,
    output t_ready, bnd_ready
  );
endinterface

// File: rtl/t_stream_feeder.sv
// -----------------------------------------------------------------------------
// t_stream_feeder
// Drives the left-hand input of PE[0] in the Smith-Waterman systolic array.
// Streams one target symbol per cycle together with the boundary column
// (v, v+alpha, f) of that row. On the first pass the boundary is all zeros;
// later passes replay the boundary delivered on the bnd_* stream. A prefetch
// FIFO is primed before streaming starts because the PEs cannot stall.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start, t_len,       pass launch (sampled only in IDLE)
//   first_pass
//   up (slave)          upstream symbol + boundary streams
//   minusAlpha          gap-open penalty (two's complement, negative)
//   newLineOut, tOut,   registered outputs to PE[0]
//   vOut, vOut_alpha,
//   fOut, validOut
//   busy, done          status: not idle / one-cycle end-of-pass pulse
//   underrun            sticky, FIFO ran empty while streaming; cleared by start
//   underrun_cnt        (only with TFEED_UNDERRUN_CNT_EN) saturating count of
//                       underrun cycles in the current pass
//
// Optional feature macro: TFEED_UNDERRUN_CNT_EN
// -----------------------------------------------------------------------------
`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif

module t_stream_feeder #(
  parameter int FIFO_AW   = 4,
  parameter int T_LEN_BIT = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [T_LEN_BIT-1:0]  t_len,
  input  logic                  first_pass,
  t_stream_feeder_if.slave      up,
  input  logic [`V_E_F_Bit-1:0] minusAlpha,
  output logic                  newLineOut,
  output logic [1:0]            tOut,
  output logic [`V_E_F_Bit-1:0] vOut,
  output logic [`V_E_F_Bit-1:0] vOut_alpha,
  output logic [`V_E_F_Bit-1:0] fOut,
  output logic                  validOut,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun
`ifdef TFEED_UNDERRUN_CNT_EN
  ,
  output logic [T_LEN_BIT-1:0]  underrun_cnt
`endif
);

  localparam int W     = `V_E_F_Bit;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int EW    = 2 + 2 * W;
  localparam logic [T_LEN_BIT-1:0] DEPTH_T = T_LEN_BIT'(DEPTH);
  localparam logic [FIFO_AW:0]     DEPTH_C = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [T_LEN_BIT-1:0]   t_len_q, t_len_d;
  logic                   fp_q, fp_d;
  logic [T_LEN_BIT-1:0]   acc_q, acc_d;
  logic [T_LEN_BIT-1:0]   pop_q, pop_d;
  logic [FIFO_AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]       count_q, count_d;
  logic                   newline_q, newline_d;
  logic [1:0]             t_q, t_d;
  logic [W-1:0]           v_q, v_d;
  logic [W-1:0]           va_q, va_d;
  logic [W-1:0]           f_q, f_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   underrun_q, underrun_d;
`ifdef TFEED_UNDERRUN_CNT_EN
  logic [T_LEN_BIT-1:0]   ucnt_q, ucnt_d;
`endif

  logic [EW-1:0]          mem_q [DEPTH];
  logic [EW-1:0]          wdata_s;
  logic [EW-1:0]          rdata_s;
  logic [T_LEN_BIT-1:0]   thresh_s;
  logic                   full_s, empty_s, allow_s, push_s, pop_s;
  logic                   t_ready_s, bnd_ready_s;

  // Handshake decode: a push only happens when every stream the pass needs is
  // valid at once, so neither the symbol nor the boundary is consumed alone.
  always_comb begin
    full_s      = (count_q == DEPTH_C);
    empty_s     = (count_q == '0);
    allow_s     = ((state_q == S_PRIME) || (state_q == S_STREAM)) &&
                  (acc_q < t_len_q) && !full_s;
    pop_s       = (state_q == S_STREAM) && !empty_s;
    wdata_s     = {up.t_char, up.bnd_v, up.bnd_f};
    rdata_s     = mem_q[rd_ptr_q];
    if (t_len_q >= DEPTH_T) begin
      thresh_s = DEPTH_T;
    end else begin
      thresh_s = t_len_q;
    end
    if (fp_q) begin
      t_ready_s   = allow_s;
      bnd_ready_s = 1'b0;
      push_s      = allow_s && up.t_valid;
    end else begin
      t_ready_s   = allow_s && up.bnd_valid;
      bnd_ready_s = allow_s && up.t_valid;
      push_s      = allow_s && up.t_valid && up.bnd_valid;
    end
  end

  assign up.t_ready   = t_ready_s;
  assign up.bnd_ready = bnd_ready_s;

  // Next-state, FIFO bookkeeping and next values of the registered PE outputs.
  always_comb begin
    state_d    = state_q;
    t_len_d    = t_len_q;
    fp_d       = fp_q;
    acc_d      = acc_q;
    pop_d      = pop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    newline_d  = 1'b0;
    t_d        = 2'b00;
    v_d        = '0;
    va_d       = '0;
    f_d        = '0;
    valid_d    = 1'b0;
    underrun_d = underrun_q;
`ifdef TFEED_UNDERRUN_CNT_EN
    ucnt_d     = ucnt_q;
`endif

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      acc_d    = acc_q + T_LEN_BIT'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          t_len_d    = t_len;
          fp_d       = first_pass;
          acc_d      = '0;
          pop_d      = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          underrun_d = 1'b0;
`ifdef TFEED_UNDERRUN_CNT_EN
          ucnt_d     = '0;
`endif
          if (t_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_PRIME;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRIME: begin
        // Short passes only need the whole pass buffered, long ones a full FIFO.
        if (T_LEN_BIT'(count_q) >= thresh_s) begin
          state_d = S_STREAM;
        end else begin
          state_d = S_PRIME;
        end
      end
      S_STREAM: begin
        if (pop_s) begin
          valid_d   = 1'b1;
          newline_d = (pop_q == '0);
          t_d       = rdata_s[EW-1 -: 2];
          if (fp_q) begin
            v_d = '0;
            f_d = '0;
          end else begin
            v_d = rdata_s[2*W-1 -: W];
            f_d = rdata_s[W-1:0];
          end
          va_d  = v_d + minusAlpha;
          pop_d = pop_q + T_LEN_BIT'(1);
          if ((pop_q + T_LEN_BIT'(1)) == t_len_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_STREAM;
          end
        end else begin
          // Starved: emit a bubble and hold the pop count so no symbol is lost.
          underrun_d = 1'b1;
`ifdef TFEED_UNDERRUN_CNT_EN
          if (ucnt_q != {T_LEN_BIT{1'b1}}) begin
            ucnt_d = ucnt_q + T_LEN_BIT'(1);
          end else begin
            ucnt_d = ucnt_q;
          end
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      t_len_q    <= '0;
      fp_q       <= 1'b0;
      acc_q      <= '0;
      pop_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      newline_q  <= 1'b0;
      t_q        <= 2'b00;
      v_q        <= '0;
      va_q       <= '0;
      f_q        <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
`ifdef TFEED_UNDERRUN_CNT_EN
      ucnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      t_len_q    <= t_len_d;
      fp_q       <= fp_d;
      acc_q      <= acc_d;
      pop_q      <= pop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      newline_q  <= newline_d;
      t_q        <= t_d;
      v_q        <= v_d;
      va_q       <= va_d;
      f_q        <= f_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
`ifdef TFEED_UNDERRUN_CNT_EN
      ucnt_q     <= ucnt_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care while the occupancy count is zero.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wdata_s;
    end
  end

  assign newLineOut = newline_q;
  assign tOut       = t_q;
  assign vOut       = v_q;
  assign vOut_alpha = va_q;
  assign fOut       = f_q;
  assign validOut   = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign underrun   = underrun_q;
`ifdef TFEED_UNDERRUN_CNT_EN
  assign underrun_cnt = ucnt_q;
`endif

endmodule
